// File: rtl/alu_share_if.sv
// alu_share_if: requester, result and shared-ALU signals of the ALU sharing arbiter.
interface alu_share_if #(parameter int WIDTH = 16, parameter int OPW = 3);
    logic             req0, req1;
    logic [OPW-1:0]   op0, op1;
    logic [WIDTH-1:0] a0, a1, b0, b1, imm0, imm1;
    logic             src0, src1;
    logic             ack0, ack1;
    logic [WIDTH-1:0] result0, result1;
    logic             lt0, lt1;
    logic [WIDTH-1:0] alu_a, alu_b, alu_imm;
    logic             alu_src;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_lt;
    logic             busy;
    logic [15:0]      op_count;

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1, imm0, imm1, src0, src1, alu_out, alu_lt,
        output ack0, ack1, result0, result1, lt0, lt1, alu_a, alu_b, alu_imm, alu_src, alu_op,
               busy, op_count
    );

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1, imm0, imm1, src0, src1, alu_out, alu_lt,
        input  ack0, ack1, result0, result1, lt0, lt1, alu_a, alu_b, alu_imm, alu_src, alu_op,
               busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a one-entry issue register and registered per-requester results.
module alu_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input logic       clk,
    input logic       reset_n,
    alu_share_if.slave bus
);
    logic [1:0]       rst_sync;
    logic             rst_i_n;
    logic             el0, el1, cap, sel;
    logic             rr, pend0, pend1, iss_valid, iss_own, ack0, ack1;
    logic             done0, done1;
    logic [WIDTH-1:0] iss_a, iss_b, iss_imm, res0, res1;
    logic [OPW-1:0]   iss_op;
    logic             iss_src, lt0, lt1;
    logic [15:0]      cnt;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};

    assign rst_i_n = rst_sync[1];

    // A requester sitting in its ack cycle is not yet allowed back in.
    assign el0   = bus.req0 & ~pend0 & ~ack0;
    assign el1   = bus.req1 & ~pend1 & ~ack1;
    assign cap   = el0 | el1;
    assign sel   = (el0 & el1) ? rr : el1;
    assign done0 = iss_valid & ~iss_own;
    assign done1 = iss_valid & iss_own;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            rr        <= 1'b0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            iss_valid <= 1'b0;
            iss_own   <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
            iss_imm   <= '0;
            iss_op    <= '0;
            iss_src   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res0      <= '0;
            res1      <= '0;
            lt0       <= 1'b0;
            lt1       <= 1'b0;
            cnt       <= '0;
        end else begin
            iss_valid <= cap;
            ack0      <= done0;
            ack1      <= done1;
            pend0     <= (pend0 & ~done0) | (cap & ~sel);
            pend1     <= (pend1 & ~done1) | (cap & sel);
            if (cap) begin
                rr      <= ~sel;
                iss_own <= sel;
                iss_a   <= sel ? bus.a1 : bus.a0;
                iss_b   <= sel ? bus.b1 : bus.b0;
                iss_imm <= sel ? bus.imm1 : bus.imm0;
                iss_op  <= sel ? bus.op1 : bus.op0;
                iss_src <= sel ? bus.src1 : bus.src0;
            end
            if (iss_valid) cnt <= cnt + 16'd1;
            if (done0) begin
                res0 <= bus.alu_out;
                lt0  <= bus.alu_lt;
            end
            if (done1) begin
                res1 <= bus.alu_out;
                lt1  <= bus.alu_lt;
            end
        end
    end

    assign bus.ack0     = ack0;
    assign bus.ack1     = ack1;
    assign bus.result0  = res0;
    assign bus.result1  = res1;
    assign bus.lt0      = lt0;
    assign bus.lt1      = lt1;
    assign bus.alu_a    = iss_a;
    assign bus.alu_b    = iss_b;
    assign bus.alu_imm  = iss_imm;
    assign bus.alu_src  = iss_src;
    assign bus.alu_op   = iss_op;
    assign bus.busy     = iss_valid;
    assign bus.op_count = cnt;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, latency, results, reset and counter wrap,
// with a behavioural model of the shared ALU closing the loop.
module tb_alu_share_arbiter;
    logic        clk;
    logic        reset_n;
    int          checks;
    int          failures;
    logic [15:0] bv, nb;

    alu_share_if #(.WIDTH(16), .OPW(3)) bus ();

    alu_share_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: negative shift amount shifts right.
    always_comb begin
        bv = bus.alu_src ? bus.alu_b : bus.alu_imm;
        nb = -bv;
        bus.alu_lt = $signed(bus.alu_a) < $signed(bv);
        case (bus.alu_op)
            3'd0:    bus.alu_out = bus.alu_a & bv;
            3'd1:    bus.alu_out = bus.alu_a | bv;
            3'd2:    bus.alu_out = bus.alu_a + bv;
            3'd3:    bus.alu_out = bus.alu_a - bv;
            3'd4:    bus.alu_out = bv[15] ? bus.alu_a >> nb : bus.alu_a << bv;
            3'd5:    bus.alu_out = {15'd0, bus.alu_lt};
            default: bus.alu_out = 16'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
        bus.a0 = 0; bus.a1 = 0; bus.b0 = 0; bus.b1 = 0;
        bus.imm0 = 0; bus.imm1 = 0; bus.src0 = 0; bus.src1 = 0;
        repeat (2) tick();
        chk("rst_acks", 32'({bus.ack0, bus.ack1}), 0);
        chk("rst_result0", 32'(bus.result0), 0);
        chk("rst_result1", 32'(bus.result1), 0);
        chk("rst_lts", 32'({bus.lt0, bus.lt1}), 0);
        chk("rst_alu", 32'({bus.alu_a, bus.alu_b}), 0);
        chk("rst_alu_misc", 32'({bus.alu_imm, bus.alu_op, bus.alu_src}), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_count", 32'(bus.op_count), 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // single ADD with immediate: 5 + 3
        bus.req0 = 1; bus.op0 = 3'd2; bus.a0 = 16'd5; bus.imm0 = 16'd3; bus.src0 = 0;
        tick();
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_alu_op", 32'(bus.alu_op), 2);
        chk("t1_alu_a", 32'(bus.alu_a), 5);
        chk("t1_early_ack", 32'(bus.ack0), 0);
        tick();
        chk("t1_ack0", 32'(bus.ack0), 1);
        chk("t1_result0", 32'(bus.result0), 8);
        chk("t1_count", 32'(bus.op_count), 1);
        bus.req0 = 0;
        tick();
        chk("t1_ack_pulse", 32'(bus.ack0), 0);
        chk("t1_idle", 32'(bus.busy), 0);

        reset_n = 1'b0;
        tick();
        chk("rst2_result0", 32'(bus.result0), 0);
        chk("rst2_count", 32'(bus.op_count), 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // both requesting continuously: 100+20 for 0, 50-8 for 1
        bus.op0 = 3'd2; bus.a0 = 16'd100; bus.b0 = 16'd20; bus.src0 = 1;
        bus.op1 = 3'd3; bus.a1 = 16'd50;  bus.b1 = 16'd8;  bus.src1 = 1;
        bus.req0 = 1; bus.req1 = 1;
        tick();
        chk("t2_first_grant", 32'(bus.alu_op), 2);
        chk("t2_busy", 32'(bus.busy), 1);
        tick();
        chk("t2_ack0", 32'({bus.ack0, bus.ack1}), 2);
        chk("t2_result0", 32'(bus.result0), 120);
        chk("t2_second_grant", 32'(bus.alu_op), 3);
        tick();
        chk("t2_ack1", 32'({bus.ack0, bus.ack1}), 1);
        chk("t2_result1", 32'(bus.result1), 42);
        tick();
        chk("t2_third_grant", 32'(bus.alu_op), 2);
        chk("t2_busy3", 32'(bus.busy), 1);
        tick();
        chk("t2_ack0_b", 32'({bus.ack0, bus.ack1}), 2);
        tick();
        chk("t2_ack1_b", 32'({bus.ack0, bus.ack1}), 1);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        chk("t2_idle", 32'(bus.busy), 0);
        chk("t2_count", 32'(bus.op_count), 4);

        // SLT on requester 1: -10 < 3
        bus.op1 = 3'd5; bus.a1 = 16'hFFF6; bus.b1 = 16'd3; bus.src1 = 1; bus.req1 = 1;
        repeat (2) tick();
        chk("t3_ack1", 32'(bus.ack1), 1);
        chk("t3_lt1", 32'(bus.lt1), 1);
        chk("t3_result1", 32'(bus.result1), 1);
        chk("t3_lt0_held", 32'(bus.lt0), 0);
        chk("t3_result0_held", 32'(bus.result0), 120);
        bus.req1 = 0;
        tick();
        chk("t3_count", 32'(bus.op_count), 5);

        // shift by negative immediate, held request re-issues with current operands
        bus.op0 = 3'd4; bus.a0 = 16'h0010; bus.imm0 = 16'hFFFE; bus.src0 = 0; bus.req0 = 1;
        repeat (2) tick();
        chk("t4_ack0", 32'(bus.ack0), 1);
        chk("t4_result0", 32'(bus.result0), 4);
        bus.a0 = 16'h0020;
        tick();
        chk("t4_ack_gap", 32'({bus.ack0, bus.busy}), 0);
        tick();
        chk("t4_reissue", 32'({bus.busy, bus.alu_a}), 32'h1_0020);
        tick();
        chk("t4_ack0_b", 32'(bus.ack0), 1);
        chk("t4_result0_b", 32'(bus.result0), 8);
        bus.req0 = 0;
        tick();
        chk("t4_count", 32'(bus.op_count), 7);

        // reset during an issue cycle discards the operation
        bus.op0 = 3'd2; bus.a0 = 16'd1; bus.imm0 = 16'd1; bus.src0 = 0; bus.req0 = 1;
        tick();
        chk("t5_issuing", 32'(bus.busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_busy_cleared", 32'(bus.busy), 0);
        chk("t5_count_cleared", 32'(bus.op_count), 0);
        bus.req0 = 0;
        tick();
        chk("t5_no_ack", 32'(bus.ack0), 0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t5_no_late_ack", 32'({bus.ack0, bus.busy}), 0);

        // counter wrap from a preset of 0xFFFF completions
        force dut.cnt = 16'hFFFF;
        #1 release dut.cnt;
        #1;
        chk("t6_preset", 32'(bus.op_count), 32'hFFFF);
        bus.op1 = 3'd2; bus.a1 = 16'd1; bus.b1 = 16'd1; bus.src1 = 1; bus.req1 = 1;
        repeat (2) tick();
        chk("t6_ack1", 32'(bus.ack1), 1);
        chk("t6_result1", 32'(bus.result1), 2);
        chk("t6_wrap", 32'(bus.op_count), 0);
        bus.req1 = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
